requantize_sample_pipe: RTL and testbench

//  Layer III requantizer datapath: xr = sign * |is|^(4/3) * 2^(exp4/4).

---
 rtl/requantize_pkg.sv | 35 +++
 rtl/rom_requantize_pow43.sv | 20 ++
 rtl/requantize_sample_pipe.sv | 147 ++++++++++++++
 tb/tb_requantize_sample_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/requantize_pkg.sv
// requantize_pkg
//   Shared widths, the 2^(r/4) gain table and the |is|^(4/3) generator
//   used by the Layer III requantizer datapath.
package requantize_pkg;

  localparam int POW43_W = 18;  // |is|^(4/3) for |is| <= 8191 peaks at 165113
  localparam int MAG_W   = 13;
  localparam int EXP4_W  = 10;
  localparam int PROD_W  = 34;  // POW43_W + 16-bit gain
  localparam int GAIN_FRAC = 14;

  // 2^(r/4) in Q2.14, r = 0..3
  localparam logic [15:0] F_TAB [4] = '{16'd16384, 16'd19484, 16'd23170, 16'd27554};

  // round(n^(4/3)) computed exactly as round(cbrt(n^4)).
  // Floor cube root is found bit by bit; the final step rounds half up by
  // testing (2x+1)^3 <= 8*n^4, i.e. x + 0.5 <= cbrt(n^4).
  function automatic logic [POW43_W-1:0] pow43_calc(input logic [MAG_W-1:0] n);
    logic [63:0] y;
    logic [63:0] x;
    logic [63:0] t;
    logic [63:0] c;
    y = 64'(n) * 64'(n);
    y = y * y;
    x = '0;
    for (int b = POW43_W - 1; b >= 0; b--) begin
      t = x | (64'd1 << b);
      if (t * t * t <= y) x = t;
    end
    c = {x[62:0], 1'b1};
    if (c * c * c <= {y[60:0], 3'b000}) x = x + 64'd1;
    return x[POW43_W-1:0];
  endfunction

endpackage

// File: rtl/rom_requantize_pow43.sv
// rom_requantize_pow43
//   Synchronous-read table of round(|is|^(4/3)), one-cycle latency.
//   clk        clock
//   en         read enable; when low read_data holds its previous value
//   read_addr  |is|, 0..8191
//   read_data  round(read_addr^(4/3)), 18-bit unsigned
module rom_requantize_pow43
  import requantize_pkg::*;
(
  input  logic               clk,
  input  logic               en,
  input  logic [MAG_W-1:0]   read_addr,
  output logic [POW43_W-1:0] read_data
);

  always_ff @(posedge clk) begin
    if (en) read_data <= pow43_calc(read_addr);
  end

endmodule

// File: rtl/requantize_sample_pipe.sv
// requantize_sample_pipe
//   Layer III requantizer: xr = sign * |is|^(4/3) * 2^(exp4/4), emitted as
//   signed fixed point Q(OUT_W-OUT_FRAC).OUT_FRAC. Three-stage pipeline with
//   valid/ready on both sides; any output stall freezes every stage.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_sign, in_mag       sign (1 = negative) and |is|
//   in_exp4               signed exponent in quarter steps
//   out_valid/out_ready   output handshake
//   out_sample            signed requantized value
//   out_last              last sample of the granule (with out_valid)
//   sat_flag              sample was clipped (with out_valid)
module requantize_sample_pipe
  import requantize_pkg::*;
#(
  parameter int OUT_W       = 24,
  parameter int OUT_FRAC    = 15,
  parameter int GRANULE_LEN = 576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MAG_W-1:0]  in_mag,
  input  logic [EXP4_W-1:0] in_exp4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_sample,
  output logic              out_last,
  output logic              sat_flag
);

  localparam int SHW   = PROD_W + OUT_W;
  localparam int CNT_W = $clog2(GRANULE_LEN);
  localparam logic [SHW-1:0]    LMAX = SHW'(2**(OUT_W-1) - 1);
  localparam logic [PROD_W:0]   RMAX = (PROD_W+1)'(2**(OUT_W-1) - 1);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // S1: ROM lookup in flight, side information registered alongside
  logic               v1, sign1;
  logic [EXP4_W-1:0]  exp1;
  logic [POW43_W-1:0] pow1;

  rom_requantize_pow43 u_rom (
    .clk       (clk),
    .en        (~stall),
    .read_addr (in_mag),
    .read_data (pow1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      exp1  <= '0;
    end else if (!stall) begin
      v1    <= in_valid;
      sign1 <= in_sign;
      exp1  <= in_exp4;
    end
  end

  // S2: exp4 = 4q + r with floor division; q is just exp4 without its two LSBs
  logic              v2, sign2;
  logic [EXP4_W-3:0] q2;
  logic [PROD_W-1:0] p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      q2    <= '0;
      p2    <= '0;
    end else if (!stall) begin
      v2    <= v1;
      sign2 <= sign1;
      q2    <= exp1[EXP4_W-1:2];
      p2    <= PROD_W'(pow1) * PROD_W'(F_TAB[exp1[1:0]]);
    end
  end

  // S3: scale by 2^s, round magnitude half up, clip, then apply sign so that
  // positive and negative values round and saturate symmetrically.
  logic [9:0]        s_amt;
  logic [9:0]        rsh;
  logic [SHW-1:0]    shl;
  logic [PROD_W:0]   rnd;
  logic [OUT_W-1:0]  mag3;
  logic              sat3;

  always_comb begin
    s_amt = {{2{q2[EXP4_W-3]}}, q2} + 10'(OUT_FRAC - GAIN_FRAC);
    rsh   = ~s_amt + 10'd1;
    shl   = '0;
    rnd   = '0;
    mag3  = '0;
    sat3  = 1'b0;
    if (!s_amt[9]) begin
      if (p2 == '0) begin
        mag3 = '0;
      end else if (s_amt >= 10'(OUT_W)) begin
        // p >= 1 shifted this far always exceeds the output range
        sat3 = 1'b1;
      end else begin
        shl = SHW'(p2) << s_amt[5:0];
        if (shl > LMAX) sat3 = 1'b1;
        else            mag3 = shl[OUT_W-1:0];
      end
    end else if (rsh <= 10'(PROD_W)) begin
      rnd = ({1'b0, p2} + ((PROD_W+1)'(1) << (rsh - 10'd1))) >> rsh;
      if (rnd > RMAX) sat3 = 1'b1;
      else            mag3 = rnd[OUT_W-1:0];
    end
    if (sat3) mag3 = LMAX[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_flag   <= 1'b0;
    end else if (!stall) begin
      out_valid  <= v2;
      out_sample <= sign2 ? (~mag3 + OUT_W'(1)) : mag3;
      sat_flag   <= sat3;
    end
  end

  // position of the current output within the granule
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (cnt == CNT_W'(GRANULE_LEN - 1)) cnt <= '0;
      else                                cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_last = out_valid & (cnt == CNT_W'(GRANULE_LEN - 1));

endmodule

// File: tb/tb_requantize_sample_pipe.sv
// tb_requantize_sample_pipe
//   Directed and random stimulus against a real-arithmetic reference of
//   xr = sign * |is|^(4/3) * 2^(exp4/4) in Q9.15 with rounding and clipping.
module tb_requantize_sample_pipe;

  localparam int     OUT_W    = 24;
  localparam int     OUT_FRAC = 15;
  localparam int     GLEN     = 576;
  localparam longint SMAX     = 8388607;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [12:0] in_mag;
  logic [9:0]  in_exp4;
  logic        out_valid, out_ready;
  logic [23:0] out_sample;
  logic        out_last, sat_flag;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    longint val;
    bit     sat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   out_cnt   = 0;
  int   last_seen = 0;

  requantize_sample_pipe #(.OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .GRANULE_LEN(GLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_mag     (in_mag),
    .in_exp4    (in_exp4),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_last   (out_last),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input longint v, input bit s);
    exp_t o;
    o.val = v;
    o.sat = s;
    return o;
  endfunction

  function automatic exp_t ref_xr(input bit sgn, input int mag, input int e4);
    exp_t o;
    int   q, r;
    real  pw, gain, v, m;
    q    = $rtoi($floor(e4 / 4.0));
    r    = e4 - 4 * q;
    pw   = $floor($pow(real'(mag), 4.0 / 3.0) + 0.5);
    gain = $floor($pow(2.0, r / 4.0) * 16384.0 + 0.5);
    v    = pw * gain * $pow(2.0, real'(q + OUT_FRAC - 14));
    m    = $floor(v + 0.5);
    o.sat = 1'b0;
    if (m > real'(SMAX)) begin
      o.sat = 1'b1;
      m = real'(SMAX);
    end
    o.val = sgn ? -longint'($rtoi(m)) : longint'($rtoi(m));
    return o;
  endfunction

  // settle, score whatever handshakes the coming rising edge performs, advance
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sample", $signed(out_sample), e.val);
        chk("sat", sat_flag, e.sat);
      end
      chk("last", out_last, (out_cnt % GLEN) == GLEN - 1);
      if (out_last) last_seen++;
      out_cnt++;
    end
    if (acc) sb.push_back(cur);
    @(negedge clk);
  endtask

  task automatic drive(input bit sgn, input int mag, input int e4, input exp_t e);
    in_valid = 1'b1;
    in_sign  = sgn;
    in_mag   = 13'(mag);
    in_exp4  = 10'(e4);
    cur      = e;
  endtask

  task automatic push_one(input bit sgn, input int mag, input int e4, input exp_t e);
    bit acc;
    int n;
    drive(sgn, mag, e4, e);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("in_timeout", 0, 1);
  endtask

  task automatic push_rand();
    bit sgn;
    int mag, e4;
    sgn = 1'($urandom % 2);
    mag = ($urandom % 4 == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 64));
    e4  = ($urandom % 8 == 0) ? int'($urandom_range(0, 1023)) - 512 : int'($urandom_range(0, 80)) - 50;
    push_one(sgn, mag, e4, ref_xr(sgn, mag, e4));
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      tick(acc);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    out_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  bit     acc;
  int     sgn_a[8], mag_a[8], e4_a[8];
  int     idx, c0;

  initial begin
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_mag    = '0;
    in_exp4   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // unity sample and its latency
    drive(1'b0, 1, 0, mk(32768, 0));
    tick(acc);
    chk("unity_accept", acc, 1);
    in_valid = 1'b0;
    chk("lat_1", out_valid, 0);
    tick(acc);
    chk("lat_2", out_valid, 0);
    tick(acc);
    chk("lat_3", out_valid, 1);
    drain();

    // fractional gains, sign, zero magnitude
    push_one(1'b1, 1, 2, mk(-46340, 0));
    push_one(1'b0, 1, -1, mk(27554, 0));
    push_one(1'b0, 8, -8, mk(131072, 0));
    push_one(1'b0, 0, 100, mk(0, 0));
    drain();

    // saturation and underflow
    push_one(1'b0, 8191, 40, mk(SMAX, 1));
    push_one(1'b1, 8191, 40, mk(-SMAX, 1));
    push_one(1'b0, 1, -400, mk(0, 0));
    drain();

    // backpressure: out_ready low for cycles 4..9 of an 8-sample burst
    for (int i = 0; i < 8; i++) begin
      sgn_a[i] = int'($urandom % 2);
      mag_a[i] = int'($urandom_range(0, 4000));
      e4_a[i]  = int'($urandom_range(0, 60)) - 40;
    end
    c0  = out_cnt;
    idx = 0;
    for (int c = 0; c < 60 && (idx < 8 || sb.size() > 0); c++) begin
      out_ready = !(c >= 4 && c <= 9);
      if (idx < 8)
        drive(1'(sgn_a[idx]), mag_a[idx], e4_a[idx], ref_xr(1'(sgn_a[idx]), mag_a[idx], e4_a[idx]));
      else
        in_valid = 1'b0;
      if (c >= 4 && c <= 9) begin
        #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
      end
      tick(acc);
      if (acc) idx++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("bp_count", out_cnt - c0, 8);
    chk("bp_queue", sb.size(), 0);

    // two full granules back to back
    do_reset();
    last_seen = 0;
    repeat (2 * GLEN) push_rand();
    drain();
    chk("granule_lasts", last_seen, 2);
    chk("granule_count", out_cnt, 2 * GLEN);

    // reset with two samples in flight
    push_rand();
    push_rand();
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    out_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_idle", out_valid, 0);
      @(negedge clk);
    end
    last_seen = 0;
    repeat (GLEN) push_rand();
    drain();
    chk("post_rst_lasts", last_seen, 1);
    chk("post_rst_count", out_cnt, GLEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
